// File: rtl/jt12_slot_regs.sv
// Operator-slot sequencer and per-slot register store with a queued host write path.
// Optional build macro JT12_SLOT_WRFWD_EN: merge a committing byte into slot_data on the same visit.
module jt12_slot_regs #(
  parameter int NUM_CH  = 6,
  parameter int FIFO_DW = 2
) (
  input  logic        i_rst,
  input  logic        i_clk,
  input  logic        i_clk_en,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [2:0]  i_wr_ch,
  input  logic [1:0]  i_wr_op,
  input  logic [2:0]  i_wr_reg,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_err,
  output logic        o_init_busy,
  output logic [2:0]  o_cur_ch,
  output logic [1:0]  o_cur_op,
  output logic        o_zero,
  output logic [55:0] o_slot_data
);

  localparam int SLOTS = 4 * NUM_CH;
  localparam int IW    = $clog2(SLOTS);
  localparam int DEPTH = 1 << FIFO_DW;
  localparam int CW    = FIFO_DW + 1;
  localparam logic [IW-1:0] NCH      = IW'(NUM_CH);
  localparam logic [2:0]    LAST_POS = 3'(NUM_CH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_init_cnt, w_init_cnt_nxt;
  logic            w_init_tc;
  logic            w_run;

  logic [2:0]      r_pos;
  logic [1:0]      r_op;
  logic [2:0]      w_nxt_pos;
  logic [1:0]      w_nxt_op;
  logic [2:0]      w_nxt_ch;
  logic [IW-1:0]   w_nxt_idx;
  logic            w_last_pos;

  logic [15:0]        r_fifo [DEPTH];
  logic [FIFO_DW-1:0] r_wptr, r_rptr;
  logic [CW-1:0]      r_count;
  logic               w_full, w_empty;
  logic [15:0]        w_head;
  logic [1:0]         w_head_op;
  logic [2:0]         w_head_ch;
  logic [2:0]         w_head_reg;
  logic [7:0]         w_head_data;
  logic               w_ch_ok, w_reg_ok, w_legal;
  logic               w_xfer, w_push, w_pop;

  logic [55:0]     r_mem [SLOTS];
  logic [55:0]     w_rd, w_rd_fwd;
  logic [55:0]     r_slot_data;
  logic            r_wr_err;

  // Position in the channel sequence maps to a channel code; the 6-channel core skips code 3.
  function automatic logic [2:0] f_pos2ch(input logic [2:0] pos);
    if (NUM_CH == 6 && pos >= 3'd3) return pos + 3'd1;
    return pos;
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_init_tc      = (r_init_cnt == '0);
    case (r_state)
      ST_INIT: begin
        if (i_clk_en) begin
          if (w_init_tc) w_state_nxt = ST_RUN;
          else           w_init_cnt_nxt = r_init_cnt - IW'(1);
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= IW'(SLOTS - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  assign w_run = (r_state == ST_RUN);

  assign w_last_pos = (r_pos == LAST_POS);
  assign w_nxt_pos  = w_last_pos ? 3'd0 : r_pos + 3'd1;
  assign w_nxt_op   = w_last_pos ? r_op + 2'd1 : r_op;
  assign w_nxt_ch   = f_pos2ch(w_nxt_pos);
  assign w_nxt_idx  = IW'(w_nxt_op) * NCH + IW'(w_nxt_pos);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos <= 3'd0;
      r_op  <= 2'd0;
    end else if (i_clk_en) begin
      r_pos <= w_nxt_pos;
      r_op  <= w_nxt_op;
    end
  end

  always_comb begin
    w_ch_ok = 1'b1;
    if (NUM_CH == 3)      w_ch_ok = (i_wr_ch < 3'd3);
    else if (NUM_CH == 6) w_ch_ok = (i_wr_ch != 3'd3) && (i_wr_ch != 3'd7);
  end

  assign w_reg_ok = (i_wr_reg <= 3'd6);
  assign w_legal  = w_ch_ok && w_reg_ok;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign o_wr_ready = w_run && !w_full;

  assign w_xfer = i_clk_en && i_wr_valid && o_wr_ready;
  assign w_push = w_xfer && w_legal;

  assign w_head      = r_fifo[r_rptr];
  assign w_head_op   = w_head[15:14];
  assign w_head_ch   = w_head[13:11];
  assign w_head_reg  = w_head[10:8];
  assign w_head_data = w_head[7:0];

  // Only the head may commit, and only as its target slot is about to become current.
  assign w_pop = i_clk_en && w_run && !w_empty &&
                 (w_head_op == w_nxt_op) && (w_head_ch == w_nxt_ch);

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wptr] <= {i_wr_op, i_wr_ch, i_wr_reg, i_wr_data};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_DW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_DW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clk_en) begin
      if (!w_run)     r_mem[w_nxt_idx] <= '0;
      else if (w_pop) r_mem[w_nxt_idx][{w_head_reg, 3'b000} +: 8] <= w_head_data;
    end
  end

  assign w_rd = r_mem[w_nxt_idx];

`ifdef JT12_SLOT_WRFWD_EN
  always_comb begin
    w_rd_fwd = w_rd;
    if (w_pop) w_rd_fwd[{w_head_reg, 3'b000} +: 8] = w_head_data;
  end
`else
  assign w_rd_fwd = w_rd;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot_data <= '0;
      r_wr_err    <= 1'b0;
    end else if (i_clk_en) begin
      r_slot_data <= w_run ? w_rd_fwd : 56'd0;
      r_wr_err    <= w_xfer && !w_legal;
    end
  end

  assign o_slot_data = r_slot_data;
  assign o_wr_err    = r_wr_err;
  assign o_init_busy = !w_run;
  assign o_cur_ch    = f_pos2ch(r_pos);
  assign o_cur_op    = r_op;
  assign o_zero      = (r_pos == 3'd0) && (r_op == 2'd0);

endmodule

// File: tb/tb_jt12_slot_regs.sv
// Directed bench for jt12_slot_regs: 6-channel instance exercised fully, 3- and 8-channel
// instances checked for slot rotation. Honours JT12_SLOT_WRFWD_EN when defined.
module tb_jt12_slot_regs;

  logic clk, rst, clk_en;
  logic wr_valid, nv;
  logic [2:0] wr_ch;
  logic [1:0] wr_op;
  logic [2:0] wr_reg;
  logic [7:0] wr_data;

  logic wr_ready, wr_err, init_busy, zero;
  logic [2:0] cur_ch;
  logic [1:0] cur_op;
  logic [55:0] slot_data;

  logic wr_ready3, wr_err3, init_busy3, zero3;
  logic [2:0] cur_ch3;
  logic [1:0] cur_op3;
  logic [55:0] slot_data3;

  logic wr_ready8, wr_err8, init_busy8, zero8;
  logic [2:0] cur_ch8;
  logic [1:0] cur_op8;
  logic [55:0] slot_data8;

  int n_assert, n_fail, cyc;
  logic exp_rdy, exp_err;
  logic [55:0] exp_slot [24];
  int seq6 [6] = '{0, 1, 2, 4, 5, 6};

  jt12_slot_regs #(.NUM_CH(6), .FIFO_DW(2)) u_dut (
    .i_rst(rst), .i_clk(clk), .i_clk_en(clk_en), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_ch(wr_ch), .i_wr_op(wr_op), .i_wr_reg(wr_reg), .i_wr_data(wr_data), .o_wr_err(wr_err),
    .o_init_busy(init_busy), .o_cur_ch(cur_ch), .o_cur_op(cur_op), .o_zero(zero),
    .o_slot_data(slot_data));

  jt12_slot_regs #(.NUM_CH(3), .FIFO_DW(2)) u_dut3 (
    .i_rst(rst), .i_clk(clk), .i_clk_en(clk_en), .i_wr_valid(nv), .o_wr_ready(wr_ready3),
    .i_wr_ch(wr_ch), .i_wr_op(wr_op), .i_wr_reg(wr_reg), .i_wr_data(wr_data), .o_wr_err(wr_err3),
    .o_init_busy(init_busy3), .o_cur_ch(cur_ch3), .o_cur_op(cur_op3), .o_zero(zero3),
    .o_slot_data(slot_data3));

  jt12_slot_regs #(.NUM_CH(8), .FIFO_DW(2)) u_dut8 (
    .i_rst(rst), .i_clk(clk), .i_clk_en(clk_en), .i_wr_valid(nv), .o_wr_ready(wr_ready8),
    .i_wr_ch(wr_ch), .i_wr_op(wr_op), .i_wr_reg(wr_reg), .i_wr_data(wr_data), .o_wr_err(wr_err8),
    .o_init_busy(init_busy8), .o_cur_ch(cur_ch8), .o_cur_op(cur_op8), .o_zero(zero8),
    .o_slot_data(slot_data8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected slot position follows directly from the number of enabled edges since reset release.
  task automatic check_all();
    int i6, i3, i8;
    i6 = cyc % 24;
    i3 = cyc % 12;
    i8 = cyc % 32;
    chk("cur_op", cur_op, i6 / 6);
    chk("cur_ch", cur_ch, seq6[i6 % 6]);
    chk("zero", zero, i6 == 0);
    chk("init_busy", init_busy, cyc < 24);
    chk("wr_ready", wr_ready, (cyc >= 24) && exp_rdy);
    chk("wr_err", wr_err, exp_err);
    if (cyc >= 24) chk("slot_data", slot_data, exp_slot[i6]);
    chk("cur_op_3ch", cur_op3, i3 / 3);
    chk("cur_ch_3ch", cur_ch3, i3 % 3);
    chk("zero_3ch", zero3, i3 == 0);
    chk("init_busy_3ch", init_busy3, cyc < 12);
    chk("cur_op_8ch", cur_op8, i8 / 8);
    chk("cur_ch_8ch", cur_ch8, i8 % 8);
    chk("zero_8ch", zero8, i8 == 0);
    chk("init_busy_8ch", init_busy8, cyc < 32);
  endtask

  task automatic tick();
    @(posedge clk);
    if (clk_en && !rst) cyc++;
    #1;
    check_all();
  endtask

  task automatic set_wr(input logic v, input logic [1:0] op, input logic [2:0] ch,
                        input logic [2:0] rg, input logic [7:0] d);
    wr_valid = v;
    wr_op    = op;
    wr_ch    = ch;
    wr_reg   = rg;
    wr_data  = d;
  endtask

  task automatic set_fifo_exp();
    exp_slot[0] = 56'(8'h11);
    exp_slot[1] = 56'(8'h22) << 16;
    exp_slot[2] = 56'(8'h33) << 24;
    exp_slot[3] = 56'(8'h44) << 32;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    exp_rdy  = 1'b1;
    exp_err  = 1'b0;
    nv       = 1'b0;
    for (int i = 0; i < 24; i++) exp_slot[i] = '0;
    rst    = 1'b1;
    clk_en = 1'b0;
    set_wr(1'b0, 2'd0, 3'd0, 3'd0, 8'h00);

    // Reset values
    repeat (3) tick();
    chk("rst_slot_data", slot_data, 56'd0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_init_busy", init_busy, 1'b1);

    // Clear sweep then one rotation of zeros
    rst    = 1'b0;
    clk_en = 1'b1;
    repeat (24) tick();
    repeat (24) tick();

    // Single legal write to (op2, ch4) reg1; cur is (0,0) here
    set_wr(1'b1, 2'd2, 3'd4, 3'd1, 8'h7F);
    tick();
    set_wr(1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    repeat (13) tick();
`ifdef JT12_SLOT_WRFWD_EN
    exp_slot[15] = 56'h7F00;
`endif
    tick();
    exp_slot[15] = 56'h7F00;
    repeat (24) tick();
    repeat (9) tick();

    // Illegal requests: channel 3, then register 7
    set_wr(1'b1, 2'd0, 3'd3, 3'd0, 8'hAA);
    exp_err = 1'b1;
    tick();
    set_wr(1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    exp_err = 1'b0;
    tick();
    set_wr(1'b1, 2'd0, 3'd0, 3'd7, 8'hBB);
    exp_err = 1'b1;
    tick();
    set_wr(1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    exp_err = 1'b0;
    tick();
    repeat (20) tick();
    repeat (24) tick();

    // Fill the queue: head waits a full rotation, fifth request is refused
    set_wr(1'b1, 2'd0, 3'd0, 3'd0, 8'h11);
    tick();
    set_wr(1'b1, 2'd0, 3'd1, 3'd2, 8'h22);
    tick();
    set_wr(1'b1, 2'd0, 3'd2, 3'd3, 8'h33);
    tick();
    set_wr(1'b1, 2'd0, 3'd4, 3'd4, 8'h44);
    exp_rdy = 1'b0;
    tick();
    clk_en = 1'b0;
    set_wr(1'b1, 2'd1, 3'd0, 3'd5, 8'h55);
    repeat (3) tick();
    clk_en = 1'b1;
    tick();
    set_wr(1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    repeat (18) tick();
    exp_rdy = 1'b1;
`ifdef JT12_SLOT_WRFWD_EN
    set_fifo_exp();
`endif
    repeat (4) tick();
    set_fifo_exp();
    repeat (21) tick();
    repeat (24) tick();

    // Reset with three writes pending
    set_wr(1'b1, 2'd1, 3'd0, 3'd1, 8'h66);
    tick();
    set_wr(1'b1, 2'd1, 3'd1, 3'd1, 8'h77);
    tick();
    set_wr(1'b1, 2'd1, 3'd2, 3'd1, 8'h88);
    tick();
    set_wr(1'b0, 2'd0, 3'd0, 3'd0, 8'h00);
    tick();
    #2;
    rst = 1'b1;
    cyc = 0;
    #1;
    chk("arst_cur_op", cur_op, 2'd0);
    chk("arst_cur_ch", cur_ch, 3'd0);
    chk("arst_zero", zero, 1'b1);
    chk("arst_slot_data", slot_data, 56'd0);
    chk("arst_wr_ready", wr_ready, 1'b0);
    chk("arst_wr_err", wr_err, 1'b0);
    chk("arst_init_busy", init_busy, 1'b1);
    for (int i = 0; i < 24; i++) exp_slot[i] = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (24) tick();
    repeat (48) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
